// File: rtl/cmp_arbiter_pkg.sv
// Shared types for the comparator arbiter: operand type, condition codes, FSM states.
// Imported by cmp_arbiter and comparators.
package cmp_arbiter_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] RV32I_OPERAND_t;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } CMP_OP_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    RESP = 2'b10
  } CMP_ARB_STATE_t;

  // Two-way round-robin: a lone requester always wins, a tie goes to the pointer.
  function automatic logic rr_grant(input logic v0, input logic v1, input logic ptr);
    logic g;
    if (v0 && v1) begin
      g = ptr;
    end else if (v1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/cmp_arbiter_comparators.sv
// Shared magnitude/equality comparator used by the branch unit and the SLT/SLTU path.
// A single borrow-subtract provides both unsigned and signed orderings.
module comparators
  import cmp_arbiter_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal,
  output logic             a_lt_b_s,
  output logic             a_lt_b_u,
  output logic             a_gt_b_s,
  output logic             a_gt_b_u
);

  logic [WIDTH:0] w_diff;
  logic           w_sign_diff;

  // Signed order only differs from unsigned when the sign bits disagree.
  always_comb begin
    w_diff      = {1'b0, a} - {1'b0, b};
    w_sign_diff = a[WIDTH-1] ^ b[WIDTH-1];
    equal       = (w_diff[WIDTH-1:0] == {WIDTH{1'b0}});
    a_lt_b_u    = w_diff[WIDTH];
    if (w_sign_diff) begin
      a_lt_b_s = a[WIDTH-1];
    end else begin
      a_lt_b_s = w_diff[WIDTH];
    end
    a_gt_b_u = !a_lt_b_u && !equal;
    a_gt_b_s = !a_lt_b_s && !equal;
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between the branch unit (req0) and SLT/SLTU (req1).
// Build option CMP_ARBITER_BYPASS_EN: skip EVAL and compare the granted operands directly in IDLE.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_result,
  output logic             rsp_err
);

  CMP_ARB_STATE_t r_state;
  logic           r_ptr;

  logic           w_any;
  logic           w_grant;
  logic           w_accept;
  RV32I_OPERAND_t w_sel_a;
  RV32I_OPERAND_t w_sel_b;
  logic [2:0]     w_sel_op;
  RV32I_OPERAND_t w_cmp_a;
  RV32I_OPERAND_t w_cmp_b;
  logic [2:0]     w_cmp_op;
  logic           w_eq;
  logic           w_lt_s;
  logic           w_lt_u;
  logic           w_gt_s_unused;
  logic           w_gt_u_unused;
  logic           w_res;
  logic           w_err;

`ifndef CMP_ARBITER_BYPASS_EN
  RV32I_OPERAND_t r_a;
  RV32I_OPERAND_t r_b;
  logic [2:0]     r_op;
  logic           r_id;
`endif

  // Both readys come from one grant bit, so at most one can be high in a cycle.
  always_comb begin
    w_any      = req0_valid | req1_valid;
    w_grant    = rr_grant(req0_valid, req1_valid, r_ptr);
    w_accept   = (r_state == IDLE) && w_any;
    req0_ready = w_accept && !w_grant;
    req1_ready = w_accept && w_grant;
    if (w_grant) begin
      w_sel_a  = req1_a;
      w_sel_b  = req1_b;
      w_sel_op = req1_op;
    end else begin
      w_sel_a  = req0_a;
      w_sel_b  = req0_b;
      w_sel_op = req0_op;
    end
  end

`ifdef CMP_ARBITER_BYPASS_EN
  assign w_cmp_a  = w_sel_a;
  assign w_cmp_b  = w_sel_b;
  assign w_cmp_op = w_sel_op;
`else
  assign w_cmp_a  = r_a;
  assign w_cmp_b  = r_b;
  assign w_cmp_op = r_op;
`endif

  comparators #(
    .WIDTH(XLEN)
  ) u_cmp (
    .a        (w_cmp_a),
    .b        (w_cmp_b),
    .equal    (w_eq),
    .a_lt_b_s (w_lt_s),
    .a_lt_b_u (w_lt_u),
    .a_gt_b_s (w_gt_s_unused),
    .a_gt_b_u (w_gt_u_unused)
  );

  // Condition decode from funct3; 010/011 are not comparisons and flag an error.
  always_comb begin
    w_res = 1'b0;
    w_err = 1'b0;
    case (CMP_OP_t'(w_cmp_op))
      BEQ:  w_res = w_eq;
      BNE:  w_res = !w_eq;
      BLT:  w_res = w_lt_s;
      BGE:  w_res = !w_lt_s;
      BLTU: w_res = w_lt_u;
      BGEU: w_res = !w_lt_u;
      default: begin
        w_res = 1'b0;
        w_err = 1'b1;
      end
    endcase
  end

  // Control FSM with registered response; the pointer moves to the loser on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= RR_INIT;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 1'b0;
      rsp_err    <= 1'b0;
`ifndef CMP_ARBITER_BYPASS_EN
      r_a        <= {XLEN{1'b0}};
      r_b        <= {XLEN{1'b0}};
      r_op       <= 3'b000;
      r_id       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ptr <= ~w_grant;
`ifdef CMP_ARBITER_BYPASS_EN
            rsp_id     <= w_grant;
            rsp_result <= w_res;
            rsp_err    <= w_err;
            rsp_valid  <= 1'b1;
            r_state    <= RESP;
`else
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_id    <= w_grant;
            r_state <= EVAL;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
`ifndef CMP_ARBITER_BYPASS_EN
        EVAL: begin
          rsp_id     <= r_id;
          rsp_result <= w_res;
          rsp_err    <= w_err;
          rsp_valid  <= 1'b1;
          r_state    <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
